// File: rtl/fib_stack_ctrl.sv
// LIFO frame stack for the Fibonacci controller: IDLE->MEM->ACK, readySig two edges after acceptance, one op per 3 cycles.
// Requests are held by the requester until readySig; FIB_STACK_ERR_EN enables sticky overflow/underflow flags and errClr.
module fib_stack_ctrl #(
   parameter int FW    = 24,
   parameter int DEPTH = 16,
   parameter int CW    = $clog2(DEPTH + 1)
) (
   input  logic          clk,
   input  logic          rstn,
   input  logic          pushSig,
   input  logic          popSig,
   input  logic [FW-1:0] din,
   output logic [FW-1:0] dout,
   output logic          readySig,
   output logic          empty,
   output logic          full,
   output logic [CW-1:0] count,
   output logic          overflow,
   output logic          underflow,
   input  logic          errClr
);

   localparam int AW = $clog2(DEPTH);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MEM  = 2'd1,
      ACK  = 2'd2
   } state_t;

   state_t        state;
   logic          op_push;
   logic [FW-1:0] din_q;
   logic [CW-1:0] sp;
   logic [FW-1:0] mem [DEPTH];

   logic          is_full;
   logic          is_empty;
   logic [AW-1:0] wr_idx;
   logic [AW-1:0] rd_idx;

   assign is_full  = (sp == CW'(DEPTH));
   assign is_empty = (sp == '0);
   assign wr_idx   = AW'(sp);
   assign rd_idx   = AW'(sp - CW'(1));

   assign count = sp;
   assign empty = is_empty;
   assign full  = is_full;

   // Operation and frame are latched in IDLE so the requester may change them once accepted.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state    <= IDLE;
         op_push  <= 1'b0;
         din_q    <= '0;
         sp       <= '0;
         dout     <= '0;
         readySig <= 1'b0;
      end else begin
         readySig <= 1'b0;
         case (state)
            IDLE: begin
               if (pushSig | popSig) begin
                  state   <= MEM;
                  op_push <= pushSig;
                  din_q   <= din;
               end
            end
            MEM: begin
               state    <= ACK;
               readySig <= 1'b1;
               if (op_push) begin
                  if (!is_full) sp <= sp + CW'(1);
               end else if (is_empty) begin
                  dout <= '0;
               end else begin
                  dout <= mem[rd_idx];
                  sp   <= sp - CW'(1);
               end
            end
            ACK:     state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   // Frame storage carries no reset; sp alone defines which entries are live.
   always_ff @(posedge clk) begin
      if (state == MEM && op_push && !is_full) mem[wr_idx] <= din_q;
   end

`ifdef FIB_STACK_ERR_EN
   logic ovf_q;
   logic unf_q;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         ovf_q <= 1'b0;
         unf_q <= 1'b0;
      end else if (errClr) begin
         ovf_q <= 1'b0;
         unf_q <= 1'b0;
      end else if (state == MEM) begin
         if (op_push && is_full)   ovf_q <= 1'b1;
         if (!op_push && is_empty) unf_q <= 1'b1;
      end
   end

   assign overflow  = ovf_q;
   assign underflow = unf_q;
`else
   logic unused_errclr;
   assign unused_errclr = errClr;
   assign overflow      = 1'b0;
   assign underflow     = 1'b0;
`endif

endmodule

// File: tb/tb_fib_stack_ctrl.sv
// Randomised bench for fib_stack_ctrl against a queue-based LIFO model; honours FIB_STACK_ERR_EN.
module tb_fib_stack_ctrl;

   localparam int FW    = 24;
   localparam int DEPTH = 16;
   localparam int CW    = $clog2(DEPTH + 1);

   logic          clk = 1'b0;
   logic          rstn;
   logic          pushSig;
   logic          popSig;
   logic [FW-1:0] din;
   logic [FW-1:0] dout;
   logic          readySig;
   logic          empty;
   logic          full;
   logic [CW-1:0] count;
   logic          overflow;
   logic          underflow;
   logic          errClr;

   fib_stack_ctrl #(.FW(FW), .DEPTH(DEPTH)) dut (
      .clk       (clk),
      .rstn      (rstn),
      .pushSig   (pushSig),
      .popSig    (popSig),
      .din       (din),
      .dout      (dout),
      .readySig  (readySig),
      .empty     (empty),
      .full      (full),
      .count     (count),
      .overflow  (overflow),
      .underflow (underflow),
      .errClr    (errClr)
   );

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_err = 0;

   // Reference model: a plain queue as the stack plus expected dout and flags.
   logic [FW-1:0] stk[$];
   logic [FW-1:0] m_dout;
   logic          m_ovf;
   logic          m_unf;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      stk.delete();
      m_dout = '0;
      m_ovf  = 1'b0;
      m_unf  = 1'b0;
   endtask

   task automatic model_op(input logic p, input logic q, input logic [FW-1:0] d);
      if (p) begin
         if (stk.size() < DEPTH) stk.push_back(d);
`ifdef FIB_STACK_ERR_EN
         else m_ovf = 1'b1;
`endif
      end else if (q) begin
         if (stk.size() > 0) m_dout = stk.pop_back();
         else begin
            m_dout = '0;
`ifdef FIB_STACK_ERR_EN
            m_unf = 1'b1;
`endif
         end
      end
   endtask

   task automatic check_state(input string tag);
      check({tag, "_count"}, 32'(count), 32'(stk.size()));
      check({tag, "_empty"}, 32'(empty), 32'(stk.size() == 0));
      check({tag, "_full"},  32'(full),  32'(stk.size() == DEPTH));
      check({tag, "_dout"},  32'(dout),  32'(m_dout));
      check({tag, "_ovf"},   32'(overflow),  32'(m_ovf));
      check({tag, "_unf"},   32'(underflow), 32'(m_unf));
   endtask

   // One request: accepted at E0, garbage on the request lines during MEM, strobe at E1, idle at E2.
   task automatic do_op(input logic p, input logic q, input logic [FW-1:0] d);
      @(negedge clk);
      pushSig = p;
      popSig  = q;
      din     = d;
      @(posedge clk); #1;
      check("rdy_mem", 32'(readySig), 32'd0);
      model_op(p, q, d);
      pushSig = 1'($urandom_range(0, 1));
      popSig  = 1'($urandom_range(0, 1));
      din     = FW'($urandom);
      @(posedge clk); #1;
      check("rdy_ack", 32'(readySig), 32'd1);
      check_state("op");
      pushSig = 1'b0;
      popSig  = 1'b0;
      @(posedge clk); #1;
      check("rdy_idle", 32'(readySig), 32'd0);
   endtask

   task automatic clear_err();
      @(negedge clk);
      errClr = 1'b1;
      @(posedge clk); #1;
      errClr = 1'b0;
      m_ovf  = 1'b0;
      m_unf  = 1'b0;
      check("clr_ovf", 32'(overflow),  32'd0);
      check("clr_unf", 32'(underflow), 32'd0);
   endtask

   initial begin
      logic [FW-1:0] last;
      int r;
      rstn    = 1'b0;
      pushSig = 1'b0;
      popSig  = 1'b0;
      din     = '0;
      errClr  = 1'b0;
      model_reset();
      #12;
      check("rst_rdy", 32'(readySig), 32'd0);
      check_state("rst");
      rstn = 1'b1;

      do_op(1'b1, 1'b0, 24'h050101);
      do_op(1'b0, 1'b1, '0);
      check("pop_050101", 32'(dout), 32'h050101);

      do_op(1'b1, 1'b0, 24'h000001);
      do_op(1'b1, 1'b0, 24'h000002);
      do_op(1'b1, 1'b0, 24'h000003);
      do_op(1'b0, 1'b1, '0);
      check("lifo_1", 32'(dout), 32'h3);
      do_op(1'b0, 1'b1, '0);
      check("lifo_2", 32'(dout), 32'h2);
      do_op(1'b0, 1'b1, '0);
      check("lifo_3", 32'(dout), 32'h1);
      check("lifo_empty", 32'(empty), 32'd1);

      last = '0;
      for (int i = 0; i < DEPTH; i++) begin
         last = FW'($urandom);
         do_op(1'b1, 1'b0, last);
      end
      do_op(1'b1, 1'b0, 24'hAAAAAA);
      check("ovf_full", 32'(full), 32'd1);
      do_op(1'b0, 1'b1, '0);
      check("ovf_top", 32'(dout), 32'(last));
      clear_err();

      for (int i = 0; i < DEPTH - 1; i++) do_op(1'b0, 1'b1, '0);
      do_op(1'b0, 1'b1, '0);
      check("unf_dout", 32'(dout), 32'd0);
      clear_err();

      last = dout;
      do_op(1'b1, 1'b1, 24'h123456);
      check("both_dout", 32'(dout), 32'(last));
      check("both_cnt", 32'(count), 32'd1);

      for (int i = 0; i < 200; i++) begin
         r = int'($urandom_range(0, 19));
         if (r < 9)       do_op(1'b1, 1'b0, FW'($urandom));
         else if (r < 17) do_op(1'b0, 1'b1, FW'($urandom));
         else if (r < 19) do_op(1'b1, 1'b1, FW'($urandom));
         else             clear_err();
      end

      do_op(1'b1, 1'b0, 24'h777777);
      @(negedge clk);
      pushSig = 1'b1;
      din     = 24'h0F0F0F;
      @(posedge clk); #1;
      rstn    = 1'b0;
      pushSig = 1'b0;
      model_reset();
      #1;
      check("mid_rst_rdy", 32'(readySig), 32'd0);
      check_state("mid_rst");
      #2;
      rstn = 1'b1;
      @(posedge clk); #1;
      check("post_rst_rdy1", 32'(readySig), 32'd0);
      @(posedge clk); #1;
      check("post_rst_rdy2", 32'(readySig), 32'd0);
      check_state("post_rst");

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule

// File: doc/fib_stack_ctrl.md
# fib_stack_ctrl

Stack responder for the Fibonacci datapath: it serves the controller's `pushSig`/`popSig` requests and answers each one with a single-cycle `readySig`. It holds recursion frames (packed n, flag and partial result) in a register-file LIFO. It owns the stack pointer, the full and empty status, and the error flags. The controller's START/PUSHBF/PUSHAF states block on `readySig` from this block.

## Interface
Parameters:
- `FW`, 24, frame width in bits (3 × 8: {n, flag, res}).
- `DEPTH`, 16, number of frames; a power of two, at least 2.
- `CW`, $clog2(DEPTH+1), width of `count`.

Ports:
- `clk`  input  1  single clock; all state updates on rising edge.
- `rstn`  input  1  asynchronous, active-low reset.
- `pushSig`  input  1  push request; level, held by the controller until `readySig`.
- `popSig`  input  1  pop request; level, held until `readySig`.
- `din`  input  FW  frame to push; sampled when the request is accepted.
- `dout`  output  FW  registered frame from the last successful pop.
- `readySig`  output  1  one-cycle completion strobe for the accepted request.
- `empty`  output  1  `count == 0`.
- `full`  output  1  `count == DEPTH`.
- `count`  output  CW  frames currently stored.
- `overflow`  output  1  sticky; set by a push while full (STACK_ERR_EN only).
- `underflow`  output  1  sticky; set by a pop while empty (STACK_ERR_EN only).
- `errClr`  input  1  synchronous clear of both sticky flags (STACK_ERR_EN only).

## Operation
- FSM states:
  - IDLE: accepts a request.
  - MEM: performs the access.
  - ACK: `readySig` = 1.
- Transitions:
  - IDLE→MEM when `pushSig | popSig` is sampled high.
  - MEM→ACK unconditionally.
  - ACK→IDLE unconditionally.
- Requests are only sampled in IDLE. Requests in MEM or ACK are ignored.
- On acceptance, the operation (push/pop) and `din` are latched. Later changes to `din` or the request lines do not affect the operation in flight.
- Simultaneous `pushSig` and `popSig`: push wins; pop is dropped with no flag.
- Push, not full: `mem[sp] <= din`, `sp <= sp+1`.
- Push, full: no write, `sp` unchanged, `overflow` set. `readySig` is still strobed.
- Pop, not empty: `dout <= mem[sp-1]`, `sp <= sp-1`.
- Pop, empty: `dout <= 0`, `sp` unchanged, `underflow` set. `readySig` is still strobed.
- `sp` ranges 0..DEPTH with no wrap-around; `count = sp`.
- `dout` holds its value until the next pop completes; pushes do not change it.
- `errClr` takes priority over a same-cycle set, so flags read 0 after the clear edge.

## Timing
- Reset values (async assert, while `rstn` = 0):
  - state = IDLE
  - `sp` = 0
  - `dout` = 0
  - `readySig` = 0
  - `empty` = 1
  - `full` = 0
  - `count` = 0
  - `overflow` = 0
  - `underflow` = 0
- Memory contents are not reset.
- Request sampled at edge E0. State is MEM for E0..E1. At E1, `sp`/`mem`/`dout`/flags update and state becomes ACK. `readySig` = 1 for exactly E1..E2; IDLE resumes at E2.
- Latency is two edges from acceptance to the `readySig` rising edge.
- Throughput is one operation per 3 cycles.
- `count`/`empty`/`full` change at E1, coincident with `readySig`.
- A request still high at E2, or re-asserted, is accepted as a new operation at E2. The controller must change state on the edge where it samples `readySig`.
- Reset mid-operation (in MEM or ACK): the operation is aborted, no `readySig` follows, and the stack is emptied.

## Configuration
- `FIB_STACK_ERR_EN` defined:
  - `overflow`/`underflow` are sticky as above.
  - `errClr` is active.
- Not defined:
  - `overflow` and `underflow` are tied to 0.
  - `errClr` is ignored.
  - Push-when-full and pop-when-empty still do nothing to `sp`/`mem`.
  - Pop-when-empty still returns `dout` = 0.
  - `readySig` is still strobed.

## Test plan
- Reset, then `pushSig` held with `din` = 0x050101 → `readySig` high exactly 2 edges after acceptance for 1 cycle; `count` = 1, `empty` = 0.
- Push 0x01, 0x02, 0x03, then pop three times → `dout` = 0x03, 0x02, 0x01 in order; `empty` = 1 after the third pop.
- Push 16 frames then a 17th with `din` = 0xAAAAAA → `full` = 1, `count` = 16, `overflow` = 1 (with macro), `readySig` strobed. The next pop returns frame 16, not 0xAAAAAA.
- Pop from empty → `dout` = 0, `underflow` = 1, `count` = 0. Then `errClr` for 1 cycle → `underflow` = 0.
- `pushSig` and `popSig` both high with `din` = 0x123456 → push performed, `count` +1, `dout` unchanged. Requests toggled during MEM/ACK are ignored.
- `rstn` pulsed low during MEM of a push → no `readySig`; `count` = 0, `empty` = 1, `dout` = 0 after release.
